dmp_cfg_ctrl: RTL and testbench

//  Programming side of the PMP/DMP checker. Holds the per-entry dmpcfg registers and the current-domain register.

---
 rtl/dmp_cfg_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmp_cfg_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmp_cfg_ctrl.sv
// DMP programming block: per-entry dmpcfg registers, CSR valid/ready access port,
// and the drain/commit/flush sequencer for current-domain switches.
module dmp_cfg_ctrl #(
    parameter int  NR_ENTRIES = 8,
    localparam int IDX_W      = $clog2(NR_ENTRIES)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    csr_req_valid_i,
    output logic                    csr_req_ready_o,
    input  logic                    csr_we_i,
    input  logic [IDX_W-1:0]        csr_idx_i,
    input  logic [7:0]              csr_wdata_i,
    output logic                    csr_rsp_valid_o,
    output logic [7:0]              csr_rdata_o,
    input  logic                    dom_sw_req_i,
    input  logic [1:0]              dom_sw_target_i,
    input  logic                    lsu_idle_i,
    output logic                    dom_sw_ack_o,
    output logic                    dom_sw_err_o,
    output logic                    flush_o,
    output logic [1:0]              curdom_o,
    output logic [NR_ENTRIES*8-1:0] dmpconf_o
);

    localparam logic [1:0] DOMI      = 2'd3;
    localparam logic [7:0] CFG_RESET = 8'h03;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Only L and the domain field are implemented; the WARL middle bits read as zero.
    function automatic logic [7:0] warl_cfg(input logic [7:0] wdata);
        return {wdata[7], 5'b00000, wdata[1:0]};
    endfunction

    state_e         state_r, state_nx_s;
    logic [7:0]     cfg_r [NR_ENTRIES];
    logic [1:0]     curdom_r, tgt_r;
    logic           ack_r, err_r, flush_r, rsp_r, ready_r;
    logic [7:0]     rdata_r;
    logic           ack_nx_s, err_nx_s, flush_nx_s;
    logic           csr_acc_s, idx_ok_s;
    logic [7:0]     cur_cfg_s, new_cfg_s;
    logic           sw_new_s, sw_same_s, sw_refuse_s;

    // The ack cycle still sees req high; it must not count as a fresh request.
    assign sw_new_s    = dom_sw_req_i & ~ack_r;
    assign sw_same_s   = (dom_sw_target_i == curdom_r);
    assign sw_refuse_s = (curdom_r != DOMI) & (dom_sw_target_i == DOMI);

    assign csr_acc_s = csr_req_valid_i & ready_r;
    assign idx_ok_s  = (int'(csr_idx_i) < NR_ENTRIES);
    assign cur_cfg_s = idx_ok_s ? cfg_r[csr_idx_i] : 8'h00;

    // Entry value after this access: locked entries and reads keep the old value.
    always_comb begin
        new_cfg_s = cur_cfg_s;
        if (csr_we_i && idx_ok_s && !cur_cfg_s[7]) begin
            new_cfg_s = warl_cfg(csr_wdata_i);
        end else begin
            new_cfg_s = cur_cfg_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (sw_new_s && !sw_same_s && !sw_refuse_s) begin
                    state_nx_s = ST_DRAIN;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (lsu_idle_i) begin
                    state_nx_s = ST_COMMIT;
                end else begin
                    state_nx_s = ST_DRAIN;
                end
            end
            ST_COMMIT: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output logic: next values of the registered pulses, so COMMIT sees ack+flush.
    always_comb begin
        ack_nx_s   = 1'b0;
        err_nx_s   = 1'b0;
        flush_nx_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sw_new_s) begin
                    ack_nx_s = sw_same_s | sw_refuse_s;
                    err_nx_s = ~sw_same_s & sw_refuse_s;
                end else begin
                    ack_nx_s = 1'b0;
                    err_nx_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                ack_nx_s   = lsu_idle_i;
                flush_nx_s = lsu_idle_i;
            end
            ST_COMMIT: begin
                ack_nx_s   = 1'b0;
                flush_nx_s = 1'b0;
            end
            default: begin
                ack_nx_s   = 1'b0;
                flush_nx_s = 1'b0;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                cfg_r[i] <= CFG_RESET;
            end
            curdom_r <= DOMI;
            tgt_r    <= DOMI;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            flush_r  <= 1'b0;
            rsp_r    <= 1'b0;
            rdata_r  <= 8'h00;
            ready_r  <= 1'b1;
        end else begin
            ack_r   <= ack_nx_s;
            err_r   <= err_nx_s;
            flush_r <= flush_nx_s;
            rsp_r   <= csr_acc_s;
            // No accept in the cycle after an accept, and none outside IDLE.
            ready_r <= (state_nx_s == ST_IDLE) & ~csr_acc_s;
            if (csr_acc_s) begin
                rdata_r <= new_cfg_s;
                if (idx_ok_s) begin
                    cfg_r[csr_idx_i] <= new_cfg_s;
                end else begin
                    rdata_r <= 8'h00;
                end
            end else begin
                rdata_r <= rdata_r;
            end
            if (state_r == ST_IDLE && state_nx_s == ST_DRAIN) begin
                tgt_r <= dom_sw_target_i;
            end else begin
                tgt_r <= tgt_r;
            end
            if (state_r == ST_COMMIT) begin
                curdom_r <= tgt_r;
            end else begin
                curdom_r <= curdom_r;
            end
        end
    end

    for (genvar g = 0; g < NR_ENTRIES; g++) begin : g_conf
        assign dmpconf_o[g*8 +: 8] = cfg_r[g];
    end

    assign csr_req_ready_o = ready_r;
    assign csr_rsp_valid_o = rsp_r;
    assign csr_rdata_o     = rdata_r;
    assign dom_sw_ack_o    = ack_r;
    assign dom_sw_err_o    = err_r;
    assign flush_o         = flush_r;
    assign curdom_o        = curdom_r;

endmodule

// File: tb/tb_dmp_cfg_ctrl.sv
// Self-checking bench for dmp_cfg_ctrl: CSR scoreboard against an entry model,
// plus domain-switch sequencing scenarios.
module tb_dmp_cfg_ctrl;

    localparam int NR = 8;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          csr_req_valid_i, csr_req_ready_o, csr_we_i;
    logic [2:0]    csr_idx_i;
    logic [7:0]    csr_wdata_i;
    logic          csr_rsp_valid_o;
    logic [7:0]    csr_rdata_o;
    logic          dom_sw_req_i;
    logic [1:0]    dom_sw_target_i;
    logic          lsu_idle_i;
    logic          dom_sw_ack_o, dom_sw_err_o, flush_o;
    logic [1:0]    curdom_o;
    logic [NR*8-1:0] dmpconf_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_cfg [NR];
    logic [7:0] exp_q [$];

    dmp_cfg_ctrl #(.NR_ENTRIES(NR)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .csr_req_valid_i(csr_req_valid_i), .csr_req_ready_o(csr_req_ready_o),
        .csr_we_i(csr_we_i), .csr_idx_i(csr_idx_i), .csr_wdata_i(csr_wdata_i),
        .csr_rsp_valid_o(csr_rsp_valid_o), .csr_rdata_o(csr_rdata_o),
        .dom_sw_req_i(dom_sw_req_i), .dom_sw_target_i(dom_sw_target_i),
        .lsu_idle_i(lsu_idle_i), .dom_sw_ack_o(dom_sw_ack_o),
        .dom_sw_err_o(dom_sw_err_o), .flush_o(flush_o),
        .curdom_o(curdom_o), .dmpconf_o(dmpconf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model_cfg[i] = 8'h03;
    endtask

    // One CSR access: wait for ready, push the model's expectation, check the response.
    task automatic csr_access(input logic we, input logic [2:0] idx, input logic [7:0] wd);
        int waited = 0;
        logic [7:0] exp_v;
        logic [7:0] got_v;
        csr_req_valid_i = 1'b1;
        csr_we_i        = we;
        csr_idx_i       = idx;
        csr_wdata_i     = wd;
        while (csr_req_ready_o !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (csr_req_ready_o !== 1'b1) begin
            $display("FAIL csr_ready_timeout: ready=%b required 1", csr_req_ready_o);
            errors++;
            csr_req_valid_i = 1'b0;
            return;
        end
        if (we && !model_cfg[idx][7]) model_cfg[idx] = {wd[7], 5'b00000, wd[1:0]};
        exp_v = model_cfg[idx];
        exp_q.push_back(exp_v);
        tick();
        csr_req_valid_i = 1'b0;
        checks++;
        if (csr_rsp_valid_o !== 1'b1) begin
            $display("FAIL csr_rsp_valid idx=%0d: got %b required 1", idx, csr_rsp_valid_o);
            errors++;
        end else begin
            got_v = exp_q.pop_front();
            checks++;
            if (csr_rdata_o !== got_v) begin
                $display("FAIL csr_rdata idx=%0d: got %h required %h", idx, csr_rdata_o, got_v);
                errors++;
            end
        end
        checks++;
        if (csr_req_ready_o !== 1'b0) begin
            $display("FAIL csr_ready_after_accept: got %b required 0", csr_req_ready_o);
            errors++;
        end
        checks++;
        if (dmpconf_o[idx*8 +: 8] !== model_cfg[idx]) begin
            $display("FAIL dmpconf idx=%0d: got %h required %h", idx, dmpconf_o[idx*8 +: 8], model_cfg[idx]);
            errors++;
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
        model_reset();
        checks++;
        if (curdom_o !== 2'd3 || dom_sw_ack_o !== 1'b0 || dom_sw_err_o !== 1'b0 || flush_o !== 1'b0) begin
            $display("FAIL reset_switch: curdom=%0d ack=%b err=%b flush=%b required 3 0 0 0",
                     curdom_o, dom_sw_ack_o, dom_sw_err_o, flush_o);
            errors++;
        end
        checks++;
        if (csr_rsp_valid_o !== 1'b0 || csr_rdata_o !== 8'h00 || csr_req_ready_o !== 1'b1) begin
            $display("FAIL reset_csr: rsp=%b rdata=%h ready=%b required 0 00 1",
                     csr_rsp_valid_o, csr_rdata_o, csr_req_ready_o);
            errors++;
        end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (dmpconf_o[i*8 +: 8] !== 8'h03) begin
                $display("FAIL reset_entry%0d: got %h required 03", i, dmpconf_o[i*8 +: 8]);
                errors++;
            end
        end
    endtask

    task automatic test_csr_rw();
        csr_access(1'b1, 3'd2, 8'h01);
        csr_access(1'b0, 3'd2, 8'hFF);
        csr_access(1'b1, 3'd4, 8'h7D);
        csr_access(1'b0, 3'd6, 8'h00);
    endtask

    task automatic test_lock();
        csr_access(1'b1, 3'd3, 8'h82);
        csr_access(1'b1, 3'd3, 8'h00);
        csr_access(1'b0, 3'd3, 8'h00);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            csr_access(1'b1, 3'(i + 4), 8'($urandom_range(0, 255)) & 8'h7F);
        end
    endtask

    task automatic test_switch_drain();
        int waited = 0;
        dom_sw_target_i = 2'd1;
        dom_sw_req_i    = 1'b1;
        lsu_idle_i      = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (dom_sw_ack_o !== 1'b0 || flush_o !== 1'b0 || csr_req_ready_o !== 1'b0) begin
                $display("FAIL drain_wait cyc%0d: ack=%b flush=%b ready=%b required 0 0 0",
                         i, dom_sw_ack_o, flush_o, csr_req_ready_o);
                errors++;
            end
        end
        lsu_idle_i = 1'b1;
        do begin
            tick();
            waited++;
        end while (dom_sw_ack_o !== 1'b1 && waited < 20);
        checks++;
        if (waited != 1 || flush_o !== 1'b1 || dom_sw_err_o !== 1'b0 || csr_req_ready_o !== 1'b0) begin
            $display("FAIL drain_commit: latency=%0d flush=%b err=%b ready=%b required 1 1 0 0",
                     waited, flush_o, dom_sw_err_o, csr_req_ready_o);
            errors++;
        end
        dom_sw_req_i = 1'b0;
        tick();
        checks++;
        if (curdom_o !== 2'd1 || dom_sw_ack_o !== 1'b0 || flush_o !== 1'b0 || csr_req_ready_o !== 1'b1) begin
            $display("FAIL drain_done: curdom=%0d ack=%b flush=%b ready=%b required 1 0 0 1",
                     curdom_o, dom_sw_ack_o, flush_o, csr_req_ready_o);
            errors++;
        end
    endtask

    task automatic test_switch_refuse();
        logic [1:0] tgts [2];
        logic       errs [2];
        tgts[0] = 2'd3; errs[0] = 1'b1;
        tgts[1] = 2'd1; errs[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            dom_sw_target_i = tgts[k];
            dom_sw_req_i    = 1'b1;
            tick();
            checks++;
            if (dom_sw_ack_o !== 1'b1 || dom_sw_err_o !== errs[k] || flush_o !== 1'b0) begin
                $display("FAIL immediate_ack tgt=%0d: ack=%b err=%b flush=%b required 1 %b 0",
                         tgts[k], dom_sw_ack_o, dom_sw_err_o, flush_o, errs[k]);
                errors++;
            end
            tick();
            dom_sw_req_i = 1'b0;
            checks++;
            if (dom_sw_ack_o !== 1'b0 || curdom_o !== 2'd1 || csr_req_ready_o !== 1'b1) begin
                $display("FAIL immediate_after tgt=%0d: ack=%b curdom=%0d ready=%b required 0 1 1",
                         tgts[k], dom_sw_ack_o, curdom_o, csr_req_ready_o);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_simultaneous();
        int waited = 0;
        lsu_idle_i      = 1'b1;
        dom_sw_target_i = 2'd0;
        dom_sw_req_i    = 1'b1;
        csr_access(1'b1, 3'd0, 8'h02);
        while (dom_sw_ack_o !== 1'b1 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (dom_sw_ack_o !== 1'b1 || flush_o !== 1'b1 || waited != 1) begin
            $display("FAIL simul_switch: ack=%b flush=%b wait=%0d required 1 1 1",
                     dom_sw_ack_o, flush_o, waited);
            errors++;
        end
        dom_sw_req_i = 1'b0;
        tick();
        checks++;
        if (curdom_o !== 2'd0 || dmpconf_o[7:0] !== 8'h02) begin
            $display("FAIL simul_done: curdom=%0d entry0=%h required 0 02", curdom_o, dmpconf_o[7:0]);
            errors++;
        end
    endtask

    task automatic test_reset_drain();
        int acks = 0;
        csr_access(1'b1, 3'd5, 8'h81);
        lsu_idle_i      = 1'b0;
        dom_sw_target_i = 2'd2;
        dom_sw_req_i    = 1'b1;
        tick();
        tick();
        rst_i        = 1'b1;
        dom_sw_req_i = 1'b0;
        tick();
        rst_i = 1'b0;
        model_reset();
        if (dom_sw_ack_o === 1'b1) acks++;
        checks++;
        if (curdom_o !== 2'd3 || csr_req_ready_o !== 1'b1 || flush_o !== 1'b0) begin
            $display("FAIL rst_drain: curdom=%0d ready=%b flush=%b required 3 1 0",
                     curdom_o, csr_req_ready_o, flush_o);
            errors++;
        end
        for (int i = 0; i < NR; i++) begin
            checks++;
            if (dmpconf_o[i*8 +: 8] !== model_cfg[i]) begin
                $display("FAIL rst_drain_entry%0d: got %h required %h", i, dmpconf_o[i*8 +: 8], model_cfg[i]);
                errors++;
            end
        end
        lsu_idle_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (dom_sw_ack_o === 1'b1 || flush_o === 1'b1) acks++;
        end
        checks++;
        if (acks != 0 || curdom_o !== 2'd3) begin
            $display("FAIL rst_drain_noack: acks=%0d curdom=%0d required 0 3", acks, curdom_o);
            errors++;
        end
    endtask

    initial begin
        rst_i           = 1'b1;
        csr_req_valid_i = 1'b0;
        csr_we_i        = 1'b0;
        csr_idx_i       = 3'd0;
        csr_wdata_i     = 8'h00;
        dom_sw_req_i    = 1'b0;
        dom_sw_target_i = 2'd3;
        lsu_idle_i      = 1'b1;
        model_reset();
        test_reset();
        test_csr_rw();
        test_lock();
        test_back_to_back();
        test_switch_drain();
        test_switch_refuse();
        test_simultaneous();
        test_reset_drain();
        checks++;
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_leftover: got %0d entries required 0", exp_q.size());
            errors++;
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
